scoreboard_forwarding_unit: RTL and testbench
=============================================

Name: scoreboard_forwarding_unit

Overview:
- Parametrised successor to the combinational forwarding logic of the 5-stage core.
- Tracks in-flight writers itself in a 3-entry stage tracker (EX, MEM, WB). From that state it produces:
  - per-read-port forwarding selects for the ID-stage operands;
  - load-use and multi-cycle-EX stall requests.
- Sits beside the decode stage, is fed by the issue handshake, and drives the operand muxes and the pipeline hold/bubble controls.

Parameters:
- N, 5: register address width.
- NUM_READ_PORTS, 2: number of ID-stage source operands checked.
- MAX_LATENCY, 8: maximum EX occupancy in cycles for multi-cycle ops (mul/div).
- LW, $clog2(MAX_LATENCY+1): width of the latency field (derived, not overridden).

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid  in  1  ID instruction moves to EX this cycle; ignored while stall=1
- issue_we  in  1  issuing instruction writes rd
- issue_rd  in  N  destination register of the issuing instruction
- issue_ready_stage  in  2  stage whose output first holds the result: 0=EX (ALU), 1=MEM (load), 2=WB only
- issue_latency  in  LW  EX occupancy in cycles; 0 or 1 = single-cycle
- flush  in  1  kill the EX entry (branch/trap redirect)
- rs_id  in  NUM_READ_PORTS*N  ID source registers, port k at [k*N +: N]
- rs_used  in  NUM_READ_PORTS  port k actually reads its source
- forward_sel  out  NUM_READ_PORTS*2  per port: 0=None, 1=FromEx, 2=FromMem, 3=FromWb
- stall  out  1  hold PC/IF/ID this cycle
- ex_busy  out  1  multi-cycle op is occupying EX

Behaviour:
- State: entries E[s] for s in {EX, MEM, WB}. Each entry holds valid, we, rd, ready_stage. EX also holds a busy counter cnt (LW bits).
- Reset (async, reset_n=0): all valid=0 and cnt=0. Outputs: forward_sel=0, stall=0, ex_busy=0.
- ex_busy = (cnt > 1).
- Match rule: port k matches entry s iff rs_used[k] && valid && we && rd==rs_id[k] && rs_id[k]!=0.
- Priority per port, youngest first: EX, then MEM, then WB.
  - The first matching entry at stage index i gives forward_sel = i+1.
  - If that entry's ready_stage > i, the port is not ready: forward_sel=0 and a hazard is raised.
  - Older matches are never used once a younger one exists.
  - No match gives forward_sel=0.
- stall = (any port hazard) || ex_busy. forward_sel and stall are combinational from current state and rs_id; there is no registered output delay.
- Clock update, in priority order:
  - flush=1:
    - EX <= bubble and cnt <= 0.
    - If cnt>1, MEM <= bubble; else MEM <= old EX (single-cycle EX op already done). WB <= old MEM.
    - issue_valid is ignored that cycle.
  - ex_busy=1:
    - EX holds and cnt <= cnt-1.
    - MEM <= bubble, WB <= MEM.
  - stall=1 (hazard only): EX <= bubble, MEM <= EX, WB <= MEM.
  - Otherwise:
    - EX <= issue entry if issue_valid, else bubble.
    - cnt <= issue_latency if issue_valid, else 0.
    - MEM <= EX, WB <= MEM.
- A multi-cycle op with latency L occupies EX for L cycles, then advances normally.
- issue_latency > MAX_LATENCY is saturated to MAX_LATENCY.
- Register 0 is never forwarded and never causes a stall.
- Two ports reading the same register receive identical selects.
- A load in MEM matched by a port forwards FromMem (ready_stage 1 == index 1). The same load in EX stalls exactly one cycle.
- reset_n deassertion mid-stream clears every tracked writer; no stale forwarding follows.

Test Plan:
- Back-to-back ALU: issue add x5 (ready 0), next cycle rs_id={x5,x0} -> forward_sel port0=1, stall=0. Following cycle -> port0=2, then 3, then 0.
- Load-use: issue lw x7 (ready 1), next cycle rs_id port1=x7 -> stall=1 for exactly one cycle, then port1=2 with stall=0.
- Priority: add x3 in WB, add x3 in MEM, rs=x3 -> forward_sel=2, never 3.
- Multi-cycle: issue mul x9 latency 4 -> ex_busy=1 for 3 cycles with stall=1. While EX is held, rs=x9 gives forward_sel=0. When the mul advances to MEM, rs=x9 gives forward_sel=2.
- Flush: mul x9 latency 4 busy, flush=1 -> next cycle ex_busy=0, stall=0, no entry matches x9.
- x0 and reset: issue add x0, rs=x0 -> sel=0, stall=0. Pulse reset_n low with 3 entries valid -> all selects 0 immediately.

Source files
------------

// File: rtl/scoreboard_forwarding_unit_if.sv
// ----------------------------------------------------------------------------
// scoreboard_forwarding_unit_if
// Bundles the issue handshake, the ID-stage operand query and the forwarding
// and stall responses of the scoreboard forwarding unit.
//   master : decode/issue side. It drives issue_*, flush, rs_id and rs_used,
//            and receives forward_sel, stall and ex_busy.
//   slave  : the scoreboard itself.
// ----------------------------------------------------------------------------
interface scoreboard_forwarding_unit_if #(
   parameter int N              = 5,
   parameter int NUM_READ_PORTS = 2,
   parameter int MAX_LATENCY    = 8
);
   localparam int LW = $clog2(MAX_LATENCY + 1);

   logic                          issue_valid;
   logic                          issue_we;
   logic [N-1:0]                  issue_rd;
   logic [1:0]                    issue_ready_stage;
   logic [LW-1:0]                 issue_latency;
   logic                          flush;
   logic [NUM_READ_PORTS*N-1:0]   rs_id;
   logic [NUM_READ_PORTS-1:0]     rs_used;
   logic [NUM_READ_PORTS*2-1:0]   forward_sel;
   logic                          stall;
   logic                          ex_busy;

   modport master (
      output issue_valid, issue_we, issue_rd, issue_ready_stage, issue_latency,
      output flush, rs_id, rs_used,
      input  forward_sel, stall, ex_busy
   );

   modport slave (
      input  issue_valid, issue_we, issue_rd, issue_ready_stage, issue_latency,
      input  flush, rs_id, rs_used,
      output forward_sel, stall, ex_busy
   );
endinterface

// File: rtl/scoreboard_forwarding_unit.sv
// ----------------------------------------------------------------------------
// scoreboard_forwarding_unit
// Tracks the writers in flight in EX, MEM and WB. From that state it produces
// the ID-stage operand forwarding selects, and it produces the stall request
// for load-use hazards and for multi-cycle EX operations.
// Ports:
//   clock    core clock
//   reset_n  asynchronous active-low reset; clears every tracked writer
//   bus      slave side of scoreboard_forwarding_unit_if, which carries:
//              issue_valid/we/rd/ready_stage/latency  instruction leaving ID
//              flush                                  kill the EX entry
//              rs_id/rs_used                          ID source operands
//              forward_sel  per port 0=None 1=EX 2=MEM 3=WB
//              stall        hold PC/IF/ID this cycle
//              ex_busy      multi-cycle op is occupying EX
// ----------------------------------------------------------------------------
module scoreboard_forwarding_unit #(
   parameter int N              = 5,
   parameter int NUM_READ_PORTS = 2,
   parameter int MAX_LATENCY    = 8
) (
   input  logic                           clock,
   input  logic                           reset_n,
   scoreboard_forwarding_unit_if.slave    bus
);
   localparam int LW = $clog2(MAX_LATENCY + 1);
   localparam logic [LW-1:0] MAX_LAT = LW'(MAX_LATENCY);

   // One tracked writer. ready_stage names the stage whose output first
   // holds the result.
   typedef struct packed {
      logic         valid;
      logic         we;
      logic [N-1:0] rd;
      logic [1:0]   ready_stage;
   } entry_t;

   // Index 0 = EX, 1 = MEM, 2 = WB. A lower index is a younger writer.
   entry_t [2:0]              stage_q;
   logic [LW-1:0]             cnt_q;

   logic                      ex_busy;
   logic                      hazard;
   logic [NUM_READ_PORTS-1:0] found;
   logic [NUM_READ_PORTS*2-1:0] fwd_sel;
   entry_t                    issue_entry;
   logic [LW-1:0]             sat_latency;

   // EX stays occupied while more than one cycle of work remains. The final
   // cycle of the op lets the pipeline advance normally.
   assign ex_busy = (cnt_q > LW'(1));

   // Each port searches the stages youngest first. The first match decides
   // the result: it either forwards from that stage or, if its result does not
   // exist there yet, it raises a hazard. Older writers of the same register
   // are shadowed by that first match. Register 0 never matches.
   always_comb begin
      hazard  = 1'b0;
      found   = '0;
      fwd_sel = '0;
      for (int k = 0; k < NUM_READ_PORTS; k++) begin
         for (int s = 0; s < 3; s++) begin
            if (!found[k] && bus.rs_used[k] && stage_q[s].valid && stage_q[s].we &&
                stage_q[s].rd == bus.rs_id[k*N +: N] && bus.rs_id[k*N +: N] != '0) begin
               found[k] = 1'b1;
               if (stage_q[s].ready_stage > 2'(s)) begin
                  hazard = 1'b1;
               end else begin
                  fwd_sel[k*2 +: 2] = 2'(s + 1);
               end
            end
         end
      end
   end

   assign bus.forward_sel = fwd_sel;
   assign bus.stall       = hazard || ex_busy;
   assign bus.ex_busy     = ex_busy;

   // Build the EX entry for an issuing instruction. Latencies larger than the
   // longest supported EX occupancy are clamped to it.
   always_comb begin
      issue_entry             = '0;
      issue_entry.valid       = 1'b1;
      issue_entry.we          = bus.issue_we;
      issue_entry.rd          = bus.issue_rd;
      issue_entry.ready_stage = bus.issue_ready_stage;
      sat_latency = (bus.issue_latency > MAX_LAT) ? MAX_LAT : bus.issue_latency;
   end

   // Advance the stage tracker. A flush has the highest priority. If the
   // flushed op was still busy, nothing leaves EX toward MEM. A finished
   // single-cycle op, however, still retires into MEM. A busy EX holds in
   // place and inserts bubbles behind it. A hazard stall inserts a bubble
   // into EX. A new issue is accepted only when none of these apply.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= '0;
         cnt_q   <= '0;
      end else if (bus.flush) begin
         stage_q[0] <= '0;
         stage_q[1] <= ex_busy ? '0 : stage_q[0];
         stage_q[2] <= stage_q[1];
         cnt_q      <= '0;
      end else if (ex_busy) begin
         stage_q[1] <= '0;
         stage_q[2] <= stage_q[1];
         cnt_q      <= cnt_q - LW'(1);
      end else if (hazard) begin
         stage_q[0] <= '0;
         stage_q[1] <= stage_q[0];
         stage_q[2] <= stage_q[1];
         cnt_q      <= '0;
      end else begin
         stage_q[0] <= bus.issue_valid ? issue_entry : '0;
         stage_q[1] <= stage_q[0];
         stage_q[2] <= stage_q[1];
         cnt_q      <= bus.issue_valid ? sat_latency : '0;
      end
   end
endmodule

// File: tb/tb_scoreboard_forwarding_unit.sv
// ----------------------------------------------------------------------------
// tb_scoreboard_forwarding_unit
// Directed bench for the scoreboard forwarding unit. Each check compares the
// vector {stall, ex_busy, forward_sel[port1], forward_sel[port0]} against a
// hand-computed value.
// ----------------------------------------------------------------------------
module tb_scoreboard_forwarding_unit;
   logic clock;
   logic reset_n;

   int checks;
   int passed;
   logic [6:0] exp_obs;
   logic [6:0] obs;
   int busy_cycles;

   scoreboard_forwarding_unit_if #(.N(5), .NUM_READ_PORTS(2), .MAX_LATENCY(8)) bus ();

   scoreboard_forwarding_unit #(.N(5), .NUM_READ_PORTS(2), .MAX_LATENCY(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign obs = {bus.stall, bus.ex_busy, bus.forward_sel};

   // Free-running clock with a 10-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present an instruction on the issue interface.
   task automatic drive_issue(input logic v, input logic [4:0] rd, input logic [1:0] rdy,
                              input logic [3:0] lat);
      bus.issue_valid       = v;
      bus.issue_we          = 1'b1;
      bus.issue_rd          = rd;
      bus.issue_ready_stage = rdy;
      bus.issue_latency     = lat;
   endtask

   // Present the ID-stage source operands, then let the outputs settle.
   task automatic drive_rs(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used);
      bus.rs_id   = {r1, r0};
      bus.rs_used = used;
      #1;
   endtask

   // Let the tracker drain with no issue and no operand reads.
   task automatic drain();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd0, 5'd0, 2'b00);
      repeat (4) tick();
   endtask

   task automatic test_reset();
      exp_obs = 7'b0_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL reset_outputs: got %b want %b", obs, exp_obs);
      else passed++;
   endtask

   task automatic test_back_to_back();
      drive_issue(1'b1, 5'd5, 2'd0, 4'd1);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd5, 5'd0, 2'b11);
      exp_obs = 7'b0_0_00_01;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL b2b_from_ex: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      exp_obs = 7'b0_0_00_10;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL b2b_from_mem: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      exp_obs = 7'b0_0_00_11;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL b2b_from_wb: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      exp_obs = 7'b0_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL b2b_retired: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
   endtask

   task automatic test_load_use();
      drive_issue(1'b1, 5'd7, 2'd1, 4'd1);
      tick();
      // The next instruction (add x8) waits in ID while the load is in EX.
      drive_issue(1'b1, 5'd8, 2'd0, 4'd1);
      drive_rs(5'd0, 5'd7, 2'b10);
      exp_obs = 7'b1_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL lu_stall: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      drive_rs(5'd8, 5'd7, 2'b11);
      exp_obs = 7'b0_0_10_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL lu_from_mem_issue_ignored: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      #1;
      exp_obs = 7'b0_0_11_01;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL lu_reissue_accepted: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
   endtask

   task automatic test_priority();
      drive_issue(1'b1, 5'd3, 2'd0, 4'd1);
      tick();
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd3, 5'd3, 2'b11);
      exp_obs = 7'b0_0_01_01;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL prio_ex_over_mem: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      exp_obs = 7'b0_0_10_10;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL prio_mem_over_wb: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      exp_obs = 7'b0_0_11_11;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL prio_wb_only: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
      // An unready load in EX shadows an older ready ALU writer in MEM.
      drive_issue(1'b1, 5'd4, 2'd0, 4'd1);
      tick();
      drive_issue(1'b1, 5'd4, 2'd1, 4'd1);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd4, 5'd0, 2'b01);
      exp_obs = 7'b1_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL prio_young_load_shadows: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      exp_obs = 7'b0_0_00_10;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL prio_load_in_mem: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
   endtask

   task automatic test_multicycle();
      drive_issue(1'b1, 5'd9, 2'd1, 4'd4);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd9, 5'd0, 2'b01);
      for (int i = 0; i < 3; i++) begin
         exp_obs = 7'b1_1_00_00;
         checks++;
         if (obs !== exp_obs) $display("[TB] FAIL mc_busy_%0d: got %b want %b", i, obs, exp_obs);
         else passed++;
         tick();
      end
      exp_obs = 7'b1_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL mc_last_cycle: got %b want %b", obs, exp_obs);
      else passed++;
      tick();
      exp_obs = 7'b0_0_00_10;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL mc_in_mem: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
   endtask

   task automatic test_saturation();
      drive_issue(1'b1, 5'd10, 2'd1, 4'd15);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      busy_cycles = 0;
      while (bus.ex_busy === 1'b1 && busy_cycles < 20) begin
         busy_cycles++;
         tick();
      end
      checks++;
      if (busy_cycles !== 7) $display("[TB] FAIL sat_busy_cycles: got %0d want %0d", busy_cycles, 7);
      else passed++;
      tick();
      drive_rs(5'd10, 5'd0, 2'b01);
      exp_obs = 7'b0_0_00_10;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL sat_in_mem: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
   endtask

   task automatic test_flush();
      drive_issue(1'b1, 5'd9, 2'd1, 4'd4);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      drive_rs(5'd9, 5'd0, 2'b01);
      exp_obs = 7'b0_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL flush_busy_mul: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
      // A finished single-cycle op in EX still retires into MEM, and an issue
      // offered during the flush is dropped.
      drive_issue(1'b1, 5'd6, 2'd0, 4'd1);
      tick();
      drive_issue(1'b1, 5'd11, 2'd0, 4'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd6, 5'd11, 2'b11);
      exp_obs = 7'b0_0_00_10;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL flush_single_cycle: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
   endtask

   task automatic test_zero_and_reset();
      drive_issue(1'b1, 5'd0, 2'd0, 4'd1);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd0, 5'd0, 2'b11);
      exp_obs = 7'b0_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL x0_alu: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
      drive_issue(1'b1, 5'd0, 2'd1, 4'd1);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd0, 5'd0, 2'b11);
      exp_obs = 7'b0_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL x0_load_no_stall: got %b want %b", obs, exp_obs);
      else passed++;
      drain();
      drive_issue(1'b1, 5'd1, 2'd0, 4'd1);
      tick();
      drive_issue(1'b1, 5'd2, 2'd0, 4'd1);
      tick();
      drive_issue(1'b1, 5'd3, 2'd0, 4'd1);
      tick();
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd2, 5'd1, 2'b11);
      exp_obs = 7'b0_0_11_10;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL pre_reset_full: got %b want %b", obs, exp_obs);
      else passed++;
      reset_n = 1'b0;
      #1;
      exp_obs = 7'b0_0_00_00;
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL async_reset_clears: got %b want %b", obs, exp_obs);
      else passed++;
      #2;
      reset_n = 1'b1;
      tick();
      drive_rs(5'd3, 5'd2, 2'b11);
      checks++;
      if (obs !== exp_obs) $display("[TB] FAIL no_stale_after_reset: got %b want %b", obs, exp_obs);
      else passed++;
   endtask

   // Run the scenarios in sequence from reset, then print the summary.
   initial begin
      checks  = 0;
      passed  = 0;
      reset_n = 1'b0;
      bus.flush = 1'b0;
      drive_issue(1'b0, 5'd0, 2'd0, 4'd0);
      drive_rs(5'd0, 5'd0, 2'b00);
      repeat (2) tick();
      test_reset();
      reset_n = 1'b1;
      tick();
      test_back_to_back();
      test_load_use();
      test_priority();
      test_multicycle();
      test_saturation();
      test_flush();
      test_zero_and_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
